// File: rtl/core_feeder_pkg.sv
// Shared widths and the FSM state encoding for the core feeder that streams data and
// weight words from their buffers to the compute engine.
package core_feeder_pkg;

  localparam int BIT_WIDTH   = 8;
  localparam int NUM_CHANNEL = 3;
  localparam int NUM_KERNEL  = 4;
  localparam int REG_WIDTH   = 32;
  localparam int ADDR_WIDTH  = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } feeder_state_e;

endpackage

// File: rtl/core_feeder_read_channel.sv
// One buffer read channel: read pointer, read enable and the fixed 1-cycle valid pipeline.
// WRAP=1 recycles the buffer (weights); WRAP=0 stops at the configured length (data).
module feeder_read_channel #(
  parameter int WORD_W = 24,
  parameter int ADDR_W = 12,
  parameter bit WRAP   = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_active,
  input  logic              i_req,
  input  logic [ADDR_W:0]   i_len,
  output logic              o_mem_en,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [WORD_W-1:0] i_mem_rdata,
  output logic [WORD_W-1:0] o_word,
  output logic              o_val,
  output logic              o_drained
);

  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W:0]   ptr_q, ptr_d;
  logic              val_q, val_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              can_read;

  // NOTE: every signal written here gets a default first, so no path through the block
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    can_read = 1'b0;
    ptr_d    = ptr_q;
    if (WRAP) begin
      can_read = i_active && i_req && (i_len != '0);
    end else begin
      can_read = i_active && i_req && (ptr_q < i_len);
    end

    if (i_clear) begin
      ptr_d = '0;
    end else if (can_read) begin
      if (WRAP && (ptr_q == i_len - PTR_ONE)) begin
        ptr_d = '0;
      end else begin
        ptr_d = ptr_q + PTR_ONE;
      end
    end

    val_d = can_read;
    // The buffer answers one cycle after the enable; keep the last word when idle.
    word_d = val_q ? i_mem_rdata : word_q;
  end

  // NOTE: flops are written with <= so every register samples the pre-edge values of
  // its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q  <= '0;
      val_q  <= 1'b0;
      word_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      val_q  <= val_d;
      word_q <= word_d;
    end
  end

  assign o_mem_en   = can_read;
  assign o_mem_addr = can_read ? ptr_q[ADDR_W-1:0] : '0;
  assign o_val      = val_q;
  assign o_word     = val_q ? i_mem_rdata : word_q;
  assign o_drained  = (ptr_q == i_len);

endmodule

// File: rtl/core_feeder.sv
// Core feeder top: start/length configuration, IDLE/RUN/DONE sequencing, and two read
// channels that serve the engine's data and weight requests from their buffers.
module core_feeder
  import core_feeder_pkg::*;
#(
  parameter int BIT_WIDTH   = core_feeder_pkg::BIT_WIDTH,
  parameter int NUM_CHANNEL = core_feeder_pkg::NUM_CHANNEL,
  parameter int NUM_KERNEL  = core_feeder_pkg::NUM_KERNEL,
  parameter int REG_WIDTH   = core_feeder_pkg::REG_WIDTH,
  parameter int ADDR_WIDTH  = core_feeder_pkg::ADDR_WIDTH
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [REG_WIDTH-1:0]                      i_conf_ctrl,
  input  logic [REG_WIDTH-1:0]                      i_conf_datalen,
  input  logic [REG_WIDTH-1:0]                      i_conf_weightlen,
  input  logic                                      i_data_req,
  input  logic                                      i_data_end,
  output logic [BIT_WIDTH*NUM_CHANNEL-1:0]          o_data,
  output logic                                      o_data_val,
  input  logic                                      i_weight_req,
  output logic [BIT_WIDTH*NUM_CHANNEL*NUM_KERNEL-1:0] o_weight,
  output logic                                      o_weight_val,
  output logic                                      o_dmem_en,
  output logic [ADDR_WIDTH-1:0]                     o_dmem_addr,
  input  logic [BIT_WIDTH*NUM_CHANNEL-1:0]          i_dmem_rdata,
  output logic                                      o_wmem_en,
  output logic [ADDR_WIDTH-1:0]                     o_wmem_addr,
  input  logic [BIT_WIDTH*NUM_CHANNEL*NUM_KERNEL-1:0] i_wmem_rdata,
  output logic                                      o_busy,
  output logic                                      o_done
);

  localparam int DATA_W   = BIT_WIDTH * NUM_CHANNEL;
  localparam int WEIGHT_W = DATA_W * NUM_KERNEL;

  feeder_state_e     state_q, state_d;
  logic              start_q, start_d;
  logic [ADDR_WIDTH:0] datalen_q, datalen_d;
  logic [ADDR_WIDTH:0] weightlen_q, weightlen_d;
  logic              start_edge;
  logic              accept_start;
  logic              run_active;
  logic              data_drained;
  logic              unused_w_drained;
  logic              unused_cfg;

  always_comb begin
    state_d      = state_q;
    start_d      = i_conf_ctrl[0];
    datalen_d    = datalen_q;
    weightlen_d  = weightlen_q;
    accept_start = 1'b0;
    start_edge   = i_conf_ctrl[0] && !start_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          accept_start = 1'b1;
          datalen_d    = i_conf_datalen[ADDR_WIDTH:0];
          weightlen_d  = i_conf_weightlen[ADDR_WIDTH:0];
          state_d      = (i_conf_datalen[ADDR_WIDTH:0] == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        // Finish once the final data word is on o_data, or when the engine calls it.
        if (i_data_end || (o_data_val && data_drained)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      start_q     <= 1'b0;
      datalen_q   <= '0;
      weightlen_q <= '0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      datalen_q   <= datalen_d;
      weightlen_q <= weightlen_d;
    end
  end

  // End-of-data stops new reads in the same cycle; reads already issued still complete.
  assign run_active = (state_q == ST_RUN) && !i_data_end;

  feeder_read_channel #(
    .WORD_W (DATA_W),
    .ADDR_W (ADDR_WIDTH),
    .WRAP   (1'b0)
  ) u_data_ch (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (accept_start),
    .i_active    (run_active),
    .i_req       (i_data_req),
    .i_len       (datalen_q),
    .o_mem_en    (o_dmem_en),
    .o_mem_addr  (o_dmem_addr),
    .i_mem_rdata (i_dmem_rdata),
    .o_word      (o_data),
    .o_val       (o_data_val),
    .o_drained   (data_drained)
  );

  feeder_read_channel #(
    .WORD_W (WEIGHT_W),
    .ADDR_W (ADDR_WIDTH),
    .WRAP   (1'b1)
  ) u_weight_ch (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (accept_start),
    .i_active    (run_active),
    .i_req       (i_weight_req),
    .i_len       (weightlen_q),
    .o_mem_en    (o_wmem_en),
    .o_mem_addr  (o_wmem_addr),
    .i_mem_rdata (i_wmem_rdata),
    .o_word      (o_weight),
    .o_val       (o_weight_val),
    .o_drained   (unused_w_drained)
  );

  assign o_busy = (state_q == ST_RUN);
  assign o_done = (state_q == ST_DONE);

  // Configuration bits outside the start flag and the length fields carry no meaning here.
  assign unused_cfg = ^{i_conf_ctrl[REG_WIDTH-1:1],
                        i_conf_datalen[REG_WIDTH-1:ADDR_WIDTH+1],
                        i_conf_weightlen[REG_WIDTH-1:ADDR_WIDTH+1],
                        unused_w_drained};

endmodule

// File: tb/tb_core_feeder.sv
// Scoreboard bench for core_feeder: expected buffer addresses are queued as requests are
// driven, and each read/valid the DUT produces is matched against them mid-cycle.
module tb_core_feeder;
  import core_feeder_pkg::*;

  localparam int DW = BIT_WIDTH * NUM_CHANNEL;
  localparam int WW = DW * NUM_KERNEL;
  localparam int AW = ADDR_WIDTH;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [REG_WIDTH-1:0] i_conf_ctrl, i_conf_datalen, i_conf_weightlen;
  logic                 i_data_req, i_data_end, i_weight_req;
  logic [DW-1:0]        o_data, dmem_rdata;
  logic                 o_data_val;
  logic [WW-1:0]        o_weight, wmem_rdata;
  logic                 o_weight_val;
  logic                 o_dmem_en, o_wmem_en;
  logic [AW-1:0]        o_dmem_addr, o_wmem_addr;
  logic                 o_busy, o_done;

  int total = 0;
  int bad   = 0;
  int cyc = 0, dreads = 0, wreads = 0, dvals = 0, wvals = 0, done_cnt = 0, busy_cnt = 0;
  int done_cyc = -1, last_dval_cyc = -1, start_cyc = 0, end_cyc = 0;
  int b_dreads, b_wreads, b_dvals, b_wvals, b_done, b_busy;
  bit d_en_prev = 1'b0;
  bit w_en_prev = 1'b0;

  logic [AW-1:0] exp_da[$];
  logic [AW-1:0] exp_wa[$];
  logic [DW-1:0] exp_dq[$];
  logic [WW-1:0] exp_wq[$];

  always #5 clk = ~clk;

  core_feeder dut (
    .clk              (clk),
    .rst              (rst),
    .i_conf_ctrl      (i_conf_ctrl),
    .i_conf_datalen   (i_conf_datalen),
    .i_conf_weightlen (i_conf_weightlen),
    .i_data_req       (i_data_req),
    .i_data_end       (i_data_end),
    .o_data           (o_data),
    .o_data_val       (o_data_val),
    .i_weight_req     (i_weight_req),
    .o_weight         (o_weight),
    .o_weight_val     (o_weight_val),
    .o_dmem_en        (o_dmem_en),
    .o_dmem_addr      (o_dmem_addr),
    .i_dmem_rdata     (dmem_rdata),
    .o_wmem_en        (o_wmem_en),
    .o_wmem_addr      (o_wmem_addr),
    .i_wmem_rdata     (wmem_rdata),
    .o_busy           (o_busy),
    .o_done           (o_done)
  );

  function automatic logic [DW-1:0] dword(input logic [AW-1:0] a);
    return (DW'(a) * DW'(24'h010203)) ^ DW'(24'h5A3C1E);
  endfunction

  function automatic logic [WW-1:0] wword(input logic [AW-1:0] a);
    return {dword(a ^ {AW{1'b1}}), dword(a + AW'(7)), DW'(a) ^ DW'(24'hC3C3C3), dword(a)};
  endfunction

  // Buffers with one cycle of read latency.
  always @(posedge clk) begin
    if (o_dmem_en) dmem_rdata <= dword(o_dmem_addr);
    if (o_wmem_en) wmem_rdata <= wword(o_wmem_addr);
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic sample(input bit want_zero);
    logic [AW-1:0] a;
    logic [DW-1:0] ed;
    logic [WW-1:0] ew;
    if (want_zero) begin
      check("rst_words", {o_data, o_weight}, '0);
      check("rst_ctrl", {o_data_val, o_weight_val, o_dmem_en, o_dmem_addr,
                         o_wmem_en, o_wmem_addr, o_busy, o_done}, '0);
    end
    if (o_data_val || d_en_prev) check("d_val_latency", o_data_val, d_en_prev);
    if (d_en_prev && exp_dq.size() > 0) begin
      ed = exp_dq.pop_front();
      if (o_data_val) check("d_word", o_data, ed);
    end
    if (o_data_val) begin
      dvals++;
      last_dval_cyc = cyc;
    end
    if (o_weight_val || w_en_prev) check("w_val_latency", o_weight_val, w_en_prev);
    if (w_en_prev && exp_wq.size() > 0) begin
      ew = exp_wq.pop_front();
      if (o_weight_val) check("w_word", o_weight, ew);
    end
    if (o_weight_val) wvals++;
    if (o_dmem_en) begin
      dreads++;
      if (exp_da.size() > 0) begin
        a = exp_da.pop_front();
        check("d_addr", o_dmem_addr, a);
        exp_dq.push_back(dword(a));
      end else begin
        check("d_read_unexpected", o_dmem_en, 1'b0);
      end
    end
    if (o_wmem_en) begin
      wreads++;
      if (exp_wa.size() > 0) begin
        a = exp_wa.pop_front();
        check("w_addr", o_wmem_addr, a);
        exp_wq.push_back(wword(a));
      end else begin
        check("w_read_unexpected", o_wmem_en, 1'b0);
      end
    end
    if (o_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (o_busy) busy_cnt++;
    d_en_prev = (o_dmem_en === 1'b1);
    w_en_prev = (o_wmem_en === 1'b1);
    // Reset at the coming edge kills any read still in flight.
    if (rst === 1'b0) begin
      d_en_prev = 1'b0;
      w_en_prev = 1'b0;
      exp_dq.delete();
      exp_wq.delete();
    end
    cyc++;
  endtask

  task automatic tick(input bit want_zero = 1'b0);
    @(negedge clk);
    sample(want_zero);
    @(posedge clk);
    #1;
  endtask

  task automatic peek_idle(input string tag, input logic [DW-1:0] dhold, input logic [WW-1:0] whold);
    @(negedge clk);
    check({tag, "_busy"}, o_busy, 1'b0);
    check({tag, "_done"}, o_done, 1'b0);
    check({tag, "_d_hold"}, o_data, dhold);
    check({tag, "_w_hold"}, o_weight, whold);
    sample(1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    b_dreads = dreads; b_wreads = wreads; b_dvals = dvals; b_wvals = wvals;
    b_done = done_cnt; b_busy = busy_cnt;
  endtask

  task automatic start_run(input int dlen, input int wlen);
    i_conf_datalen   = 32'hFFFF_0000 | REG_WIDTH'(dlen);
    i_conf_weightlen = 32'hFFFF_0000 | REG_WIDTH'(wlen);
    i_conf_ctrl      = 32'hA5A5_0001;
    start_cyc        = cyc;
    tick();
    i_conf_ctrl      = 32'hA5A5_0000;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done_cnt == b_done && n < 40) begin
      tick();
      n++;
    end
    check("done_seen", done_cnt - b_done, 1);
    tick();
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_da_left"}, exp_da.size(), 0);
    check({tag, "_wa_left"}, exp_wa.size(), 0);
    check({tag, "_dq_left"}, exp_dq.size(), 0);
    check({tag, "_wq_left"}, exp_wq.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    i_conf_ctrl = '0; i_conf_datalen = '0; i_conf_weightlen = '0;
    i_data_req = 1'b0; i_data_end = 1'b0; i_weight_req = 1'b0;
    @(posedge clk);
    #1;
    tick(1'b1);
    rst = 1'b1;
    tick();

    // datalen=4, request held for 6 cycles.
    snap();
    start_run(4, 0);
    for (int i = 0; i < 6; i++) begin
      i_data_req = 1'b1;
      if (i < 4) exp_da.push_back(AW'(i));
      tick();
    end
    i_data_req = 1'b0;
    wait_done();
    check("a_reads", dreads - b_dreads, 4);
    check("a_vals", dvals - b_dvals, 4);
    check("a_done_after_last_val", done_cyc, last_dval_cyc + 1);
    check("a_busy_cycles", busy_cnt - b_busy, 5);
    check_drained("a");
    peek_idle("a_idle", dword(3), '0);

    // Weights wrap at weightlen=3 while data streams concurrently.
    snap();
    start_run(100, 3);
    for (int i = 0; i < 7; i++) begin
      i_data_req = 1'b1;
      i_weight_req = 1'b1;
      exp_da.push_back(AW'(i));
      exp_wa.push_back(AW'(i % 3));
      tick();
    end
    i_data_req = 1'b0;
    i_weight_req = 1'b0;
    i_data_end = 1'b1;
    end_cyc = cyc;
    tick();
    i_data_end = 1'b0;
    wait_done();
    check("b_wreads", wreads - b_wreads, 7);
    check("b_wvals", wvals - b_wvals, 7);
    check("b_dreads", dreads - b_dreads, 7);
    check("b_done_after_end", done_cyc, end_cyc + 1);
    check_drained("b");
    peek_idle("b_idle", dword(6), wword(0));

    // Engine ends early after 3 of 8 words.
    snap();
    start_run(8, 0);
    for (int i = 0; i < 4; i++) begin
      i_data_req = 1'b1;
      i_data_end = (i == 3);
      if (i < 3) exp_da.push_back(AW'(i));
      tick();
    end
    i_data_req = 1'b0;
    i_data_end = 1'b0;
    wait_done();
    check("c_reads", dreads - b_dreads, 3);
    check("c_vals", dvals - b_dvals, 3);
    check("c_done_after_last_val", done_cyc, last_dval_cyc + 1);
    check_drained("c");
    peek_idle("c_idle", dword(2), wword(0));

    // datalen=0: immediate done, no reads, never busy.
    snap();
    i_data_req = 1'b1;
    i_weight_req = 1'b1;
    start_run(0, 3);
    for (int i = 0; i < 3; i++) tick();
    i_data_req = 1'b0;
    i_weight_req = 1'b0;
    check("d_done_count", done_cnt - b_done, 1);
    check("d_done_timing", done_cyc, start_cyc + 1);
    check("d_no_dreads", dreads - b_dreads, 0);
    check("d_no_wreads", wreads - b_wreads, 0);
    check("d_never_busy", busy_cnt - b_busy, 0);

    // Reset mid-run: the read issued in the reset cycle never becomes valid.
    snap();
    start_run(8, 0);
    for (int i = 0; i < 3; i++) begin
      i_data_req = 1'b1;
      exp_da.push_back(AW'(i));
      if (i == 2) rst = 1'b0;
      tick();
    end
    rst = 1'b1;
    i_data_req = 1'b0;
    tick(1'b1);
    for (int i = 0; i < 4; i++) tick();
    check("e_no_done", done_cnt - b_done, 0);
    check("e_vals", dvals - b_dvals, 2);
    check("e_reads", dreads - b_dreads, 3);
    check_drained("e");
    snap();
    start_run(2, 0);
    for (int i = 0; i < 2; i++) begin
      i_data_req = 1'b1;
      exp_da.push_back(AW'(i));
      tick();
    end
    i_data_req = 1'b0;
    wait_done();
    check("e_restart_reads", dreads - b_dreads, 2);
    check_drained("e_restart");

    // Start held high for 10 cycles; weightlen=0 gives no weight reads.
    snap();
    i_conf_datalen = 32'd2;
    i_conf_weightlen = 32'd0;
    exp_da.push_back(AW'(0));
    exp_da.push_back(AW'(1));
    for (int i = 0; i < 10; i++) begin
      i_conf_ctrl = 32'd1;
      i_data_req = 1'b1;
      i_weight_req = 1'b1;
      tick();
    end
    i_conf_ctrl = '0;
    i_data_req = 1'b0;
    i_weight_req = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("f_held_runs", done_cnt - b_done, 1);
    check("f_held_reads", dreads - b_dreads, 2);
    check("f_wlen0_reads", wreads - b_wreads, 0);
    check_drained("f_held");

    // Start re-pulsed during RUN and DONE is ignored.
    snap();
    start_run(4, 0);
    for (int i = 0; i < 6; i++) begin
      i_data_req = 1'b1;
      i_conf_ctrl = (i == 1 || i == 5) ? 32'd1 : 32'd0;
      if (i < 4) exp_da.push_back(AW'(i));
      tick();
    end
    i_data_req = 1'b0;
    i_conf_ctrl = '0;
    for (int i = 0; i < 4; i++) tick();
    check("f_repulse_runs", done_cnt - b_done, 1);
    check("f_repulse_reads", dreads - b_dreads, 4);
    check_drained("f_repulse");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
